// File: rtl/spi_slave_responder_pkg.sv
// spi_pkg: shared widths, timing constant and FSM state type for the SPI slave responder
package spi_pkg;
  localparam int SPI_DATA_W = 12;
  localparam int SPI_CLK_DIV = 10;
  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_CS} slave_state_t;
endpackage

// File: rtl/spi_slave_responder_if.sv
// spi_slave_responder_if: tx/rx word handshake, status pulses and SPI pins of the responder
interface spi_slave_responder_if import spi_pkg::*; #(
  parameter int DATA_W = SPI_DATA_W
);
  logic [DATA_W-1:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic rx_valid;
  logic tx_underrun;
  logic frame_err;
  logic busy;
  logic sclk;
  logic cs;
  logic mosi;
  logic miso;
  modport slave (
    input tx_data, tx_valid, sclk, cs, mosi,
    output tx_ready, rx_data, rx_valid, tx_underrun, frame_err, busy, miso
  );
  modport master (
    output tx_data, tx_valid, sclk, cs, mosi,
    input tx_ready, rx_data, rx_valid, tx_underrun, frame_err, busy, miso
  );
endinterface

// File: rtl/spi_slave_responder_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with one extra flop for rise/fall detection
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES:0] sr;
  always_ff @(posedge clk)
    if (!rst) sr <= {(SYNC_STAGES + 1){RST_VAL}};
    else sr <= {sr[SYNC_STAGES-1:0], d};
  assign q = sr[SYNC_STAGES-1];
  assign rise = sr[SYNC_STAGES-1] & ~sr[SYNC_STAGES];
  assign fall = ~sr[SYNC_STAGES-1] & sr[SYNC_STAGES];
endmodule

// File: rtl/spi_slave_responder.sv
// spi_slave_responder: oversampled full-duplex LSB-first SPI slave with a one-entry tx holding buffer
module spi_slave_responder import spi_pkg::*; #(
  parameter int DATA_W = SPI_DATA_W,
  parameter int SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] FILL_WORD = '0
) (
  input logic clk,
  input logic rst,
  spi_slave_responder_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  slave_state_t state;
  logic buf_full;
  logic [DATA_W-1:0] buf_data, tx_sr, rx_sr, next_rx, load_word;
  logic [CNT_W-1:0] cnt;
  logic sclk_q, sclk_rise, sclk_fall, cs_q, cs_rise, cs_fall, mosi_q, mosi_rise, mosi_fall;
  logic accept, start, unused_sync;
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .d(bus.sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .d(bus.cs), .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .d(bus.mosi), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
  );
  assign unused_sync = ^{sclk_q, cs_q, mosi_rise, mosi_fall};
  assign accept = bus.tx_valid & ~buf_full;
  assign start = (state == IDLE) & cs_fall;
  assign load_word = buf_full ? buf_data : FILL_WORD;
  assign next_rx = {mosi_q, rx_sr[DATA_W-1:1]};
  assign bus.tx_ready = ~buf_full;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      buf_full <= 1'b0;
      buf_data <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      cnt <= '0;
      bus.rx_data <= '0;
      bus.rx_valid <= 1'b0;
      bus.tx_underrun <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.miso <= 1'b0;
    end else begin
      bus.rx_valid <= 1'b0;
      bus.tx_underrun <= 1'b0;
      bus.frame_err <= 1'b0;
      buf_full <= start ? accept : (buf_full | accept);
      if (accept) buf_data <= bus.tx_data;
      case (state)
        IDLE: begin
          bus.miso <= 1'b0;
          if (cs_fall) begin
            state <= SHIFT;
            cnt <= '0;
            tx_sr <= load_word;
            bus.miso <= load_word[0];
            bus.tx_underrun <= ~buf_full;
          end
        end
        SHIFT:
          if (cs_rise) begin
            state <= IDLE;
            bus.frame_err <= 1'b1;
            bus.miso <= 1'b0;
          end else begin
            if (sclk_rise) begin
              rx_sr <= next_rx;
              cnt <= cnt + 1'b1;
              if (cnt == CNT_W'(DATA_W - 1)) begin
                bus.rx_data <= next_rx;
                bus.rx_valid <= 1'b1;
                state <= WAIT_CS;
              end
            end
            if (sclk_fall) begin
              tx_sr <= tx_sr >> 1;
              bus.miso <= tx_sr[1];
            end
          end
        WAIT_CS:
          if (cs_rise) begin
            state <= IDLE;
            bus.miso <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_slave_responder.sv
// tb_spi_slave_responder: randomized SPI master with queue-based scoreboard and word-level reference model
module tb_spi_slave_responder;
  import spi_pkg::*;
  localparam int W = SPI_DATA_W;
  localparam int HALF = SPI_CLK_DIV;
  logic clk = 1'b0;
  logic rst = 1'b0;
  spi_slave_responder_if #(.DATA_W(W)) bus ();
  spi_slave_responder #(.DATA_W(W), .SYNC_STAGES(2), .FILL_WORD('0)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  int n_checks = 0;
  int n_fail = 0;
  int ur_seen = 0;
  int fe_seen = 0;
  int ur_exp = 0;
  int fe_exp = 0;
  logic [W-1:0] exp_rx[$];
  logic [W-1:0] model_buf[$];
  logic [W-1:0] last_rx = '0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (rst) begin
      if (bus.rx_valid) begin
        if (exp_rx.size() == 0) check("unexpected_rx_valid", 32'd1, 32'd0);
        else begin
          e = exp_rx.pop_front();
          check("rx_data", 32'(bus.rx_data), 32'(e));
        end
      end
      if (bus.tx_underrun) ur_seen++;
      if (bus.frame_err) fe_seen++;
    end
  end
  task automatic send_tx(input logic [W-1:0] w);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.tx_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("tx_ready_before_offer", 32'(bus.tx_ready), 32'd1);
    bus.tx_data = w;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    model_buf.push_back(w);
  endtask
  task automatic spi_frame(input logic [W-1:0] mo, input int nrise, input bit chk_ready);
    logic [W-1:0] exp_tx, got, mask;
    bit ur;
    ur = model_buf.size() == 0;
    exp_tx = ur ? '0 : model_buf.pop_front();
    if (ur) ur_exp++;
    if (nrise >= W) begin
      exp_rx.push_back(mo);
      last_rx = mo;
    end else fe_exp++;
    got = '0;
    mask = (nrise >= W) ? '1 : (W'(1) << nrise) - W'(1);
    @(negedge clk);
    bus.cs = 1'b0;
    repeat (HALF) @(negedge clk);
    check("busy_in_frame", 32'(bus.busy), 32'd1);
    if (chk_ready) check("tx_ready_after_load", 32'(bus.tx_ready), 32'd1);
    for (int i = 0; i < nrise; i++) begin
      bus.mosi = (i < W) ? mo[i] : 1'($urandom);
      repeat (HALF) @(negedge clk);
      bus.sclk = 1'b1;
      if (i < W) got[i] = bus.miso;
      else check("miso_hold_extra_edge", 32'(bus.miso), 32'(exp_tx[W-1]));
      repeat (HALF) @(negedge clk);
      bus.sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    check("miso_word", 32'(got & mask), 32'(exp_tx & mask));
    bus.cs = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    check("underrun_count", 32'(ur_seen), 32'(ur_exp));
    check("frame_err_count", 32'(fe_seen), 32'(fe_exp));
    check("rx_pending", 32'(exp_rx.size()), 32'd0);
    check("rx_data_hold", 32'(bus.rx_data), 32'(last_rx));
    check("busy_after_frame", 32'(bus.busy), 32'd0);
    check("miso_idle", 32'(bus.miso), 32'd0);
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    bus.cs = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_miso", 32'(bus.miso), 32'd0);
    check("reset_rx_data", 32'(bus.rx_data), 32'd0);
    check("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("reset_underrun", 32'(bus.tx_underrun), 32'd0);
    check("reset_frame_err", 32'(bus.frame_err), 32'd0);
    send_tx(12'hA5C);
    check("tx_ready_after_accept", 32'(bus.tx_ready), 32'd0);
    spi_frame(12'h3F1, W, 1'b1);
    spi_frame(12'h001, W, 1'b1);
    spi_frame(W'($urandom), 5, 1'b1);
    spi_frame(12'hFFF, W, 1'b1);
    @(negedge clk);
    bus.tx_data = 12'h111;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    check("handshake_ready_low", 32'(bus.tx_ready), 32'd0);
    bus.tx_data = 12'h222;
    model_buf.push_back(12'h111);
    model_buf.push_back(12'h222);
    repeat (5) @(negedge clk);
    spi_frame(W'($urandom), W, 1'b0);
    bus.tx_valid = 1'b0;
    check("handshake_second_buffered", 32'(bus.tx_ready), 32'd0);
    spi_frame(W'($urandom), W, 1'b1);
    send_tx(W'($urandom));
    void'(model_buf.pop_front());
    @(negedge clk);
    bus.cs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      bus.mosi = 1'($urandom);
      repeat (HALF) @(negedge clk);
      bus.sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    rst = 1'b0;
    bus.cs = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    last_rx = '0;
    check("midreset_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_miso", 32'(bus.miso), 32'd0);
    check("midreset_rx_data", 32'(bus.rx_data), 32'd0);
    repeat (3 * HALF) @(negedge clk);
    check("midreset_no_underrun", 32'(ur_seen), 32'(ur_exp));
    check("midreset_no_frame_err", 32'(fe_seen), 32'(fe_exp));
    spi_frame(W'($urandom), W, 1'b1);
    send_tx(W'($urandom));
    spi_frame(W'($urandom), W + 2, 1'b1);
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(1, 0) == 1) send_tx(W'($urandom));
      case ($urandom_range(3, 0))
        0: n = $urandom_range(W - 1, 1);
        1: n = W + $urandom_range(3, 1);
        default: n = W;
      endcase
      spi_frame(W'($urandom), n, 1'b1);
    end
    repeat (20) @(negedge clk);
    check("final_rx_queue_empty", 32'(exp_rx.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
